// File: rtl/lcd_string_writer.sv
// rtl/lcd_string_writer.sv - HD44780 16x2 LCD power-up init and continuous two-line refresh
// Streams characters from a combinational string ROM into DDRAM, restarting at line 1 when state_code changes.
module lcd_string_writer #(
  parameter int PWRUP_CYC = 750000,
  parameter int EN_CYC    = 12,
  parameter int SETUP_CYC = 2,
  parameter int CMD_CYC   = 2500,
  parameter int CLR_CYC   = 100000
) (
  input  logic       clk_50Mhz,
  input  logic       reset_n,
  input  logic [4:0] state_code,
  input  logic [7:0] char_data,
  output logic [4:0] char_index,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_A   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int MAX_B   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
  localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_L1_ADDR, S_L1_CHAR, S_L2_ADDR, S_L2_CHAR
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_GAP} phase_t;

  state_t        state, state_nxt, load_state;
  phase_t        phase, phase_nxt;
  logic [CW-1:0] cnt, cnt_nxt, gap_last;
  logic [2:0]    init_step, step_nxt;
  logic [4:0]    index_nxt, sc_reg;
  logic [7:0]    data_nxt;
  logic          rs_nxt, en_nxt, init_done_nxt, frame_done_nxt;
  logic          restart_pend, pend_nxt;
  logic          load, refresh, sc_changed;

  function automatic logic [7:0] init_cmd(input logic [2:0] step);
    case (step)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h38;
      3'd2:    init_cmd = 8'h0C;
      3'd3:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign LCD_RW = 1'b0;

  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    cnt_nxt        = cnt + 1'b1;
    step_nxt       = init_step;
    index_nxt      = char_index;
    data_nxt       = LCD_DATA;
    rs_nxt         = LCD_RS;
    en_nxt         = LCD_EN;
    init_done_nxt  = init_done;
    frame_done_nxt = 1'b0;
    pend_nxt       = restart_pend;
    load           = 1'b0;
    load_state     = state;
    refresh        = (state != S_PWRUP) && (state != S_INIT);
    sc_changed     = (state_code != sc_reg);
    gap_last       = (!LCD_RS && LCD_DATA == 8'h01) ? CLR_LAST : CMD_LAST;

    if (refresh && sc_changed) pend_nxt = 1'b1;

    if (state == S_PWRUP) begin
      if (cnt == PWRUP_LAST) begin
        load       = 1'b1;
        load_state = S_INIT;
        step_nxt   = 3'd0;
      end
    end else begin
      case (phase)
        PH_SETUP: begin
          if (cnt == SETUP_LAST) begin
            phase_nxt = PH_STROBE;
            cnt_nxt   = '0;
            en_nxt    = 1'b1;
          end
        end
        PH_STROBE: begin
          // Advancing the ROM address at EN fall gives char_data the whole gap to settle.
          if (cnt == EN_LAST) begin
            phase_nxt = PH_GAP;
            cnt_nxt   = '0;
            en_nxt    = 1'b0;
            if (LCD_RS) index_nxt = char_index + 1'b1;
          end
        end
        default: begin
          if (cnt == gap_last) begin
            load = 1'b1;
            case (state)
              S_INIT: begin
                if (init_step == 3'd4) begin
                  init_done_nxt = 1'b1;
                  load_state    = S_L1_ADDR;
                end else begin
                  step_nxt   = init_step + 1'b1;
                  load_state = S_INIT;
                end
              end
              S_L1_ADDR: load_state = S_L1_CHAR;
              S_L1_CHAR: load_state = (char_index == 5'h10) ? S_L2_ADDR : S_L1_CHAR;
              S_L2_ADDR: load_state = S_L2_CHAR;
              S_L2_CHAR: begin
                if (char_index == 5'h00) begin
                  load_state     = S_L1_ADDR;
                  frame_done_nxt = 1'b1;
                end else begin
                  load_state = S_L2_CHAR;
                end
              end
              default: load_state = S_L1_ADDR;
            endcase
            // Any message change seen during this write folds into a single restart.
            if (refresh && (restart_pend || sc_changed)) begin
              load_state     = S_L1_ADDR;
              frame_done_nxt = 1'b0;
            end
            if (refresh) pend_nxt = 1'b0;
          end
        end
      endcase
    end

    if (load) begin
      state_nxt = load_state;
      phase_nxt = PH_SETUP;
      cnt_nxt   = '0;
      case (load_state)
        S_INIT: begin
          rs_nxt   = 1'b0;
          data_nxt = init_cmd(step_nxt);
        end
        S_L1_ADDR: begin
          rs_nxt    = 1'b0;
          data_nxt  = 8'h80;
          index_nxt = 5'h00;
        end
        S_L2_ADDR: begin
          rs_nxt   = 1'b0;
          data_nxt = 8'hC0;
        end
        default: begin
          rs_nxt   = 1'b1;
          data_nxt = char_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_PWRUP;
      phase        <= PH_SETUP;
      cnt          <= '0;
      init_step    <= 3'd0;
      char_index   <= 5'h00;
      LCD_DATA     <= 8'h00;
      LCD_RS       <= 1'b0;
      LCD_EN       <= 1'b0;
      LCD_ON       <= 1'b0;
      init_done    <= 1'b0;
      frame_done   <= 1'b0;
      sc_reg       <= 5'h00;
      restart_pend <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      cnt          <= cnt_nxt;
      init_step    <= step_nxt;
      char_index   <= index_nxt;
      LCD_DATA     <= data_nxt;
      LCD_RS       <= rs_nxt;
      LCD_EN       <= en_nxt;
      LCD_ON       <= 1'b1;
      init_done    <= init_done_nxt;
      frame_done   <= frame_done_nxt;
      sc_reg       <= state_code;
      restart_pend <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_string_writer.sv
// tb/tb_lcd_string_writer.sv - directed self-checking bench for lcd_string_writer
// Includes a small string ROM model; LCD bytes are captured on each LCD_EN falling edge.
module tb_lcd_string_writer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] state_code = 5'b00000;
  logic [7:0] char_data;
  logic [4:0] char_index;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, init_done, frame_done;

  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  int fd_qsize = -1;
  logic [8:0] cap[$];

  always #5 clk = ~clk;

  lcd_string_writer #(
    .PWRUP_CYC(20), .EN_CYC(3), .SETUP_CYC(2), .CMD_CYC(5), .CLR_CYC(15)
  ) dut (
    .clk_50Mhz(clk), .reset_n(reset_n), .state_code(state_code),
    .char_data(char_data), .char_index(char_index), .LCD_DATA(LCD_DATA),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON),
    .init_done(init_done), .frame_done(frame_done)
  );

  function automatic logic [7:0] rom_char(input logic [4:0] sc, input logic [4:0] idx);
    string s;
    int p;
    s = "";
    if (sc == 5'b00000) s = idx[4] ? "Press Ok" : "Start";
    else if (sc == 5'b10000) s = idx[4] ? "Bye" : "Done";
    p = int'(idx[3:0]);
    rom_char = (p < s.len()) ? 8'(s[p]) : 8'h20;
  endfunction

  assign char_data = rom_char(state_code, char_index);

  always @(negedge LCD_EN) if (reset_n) cap.push_back({LCD_RS, LCD_DATA});

  always @(negedge clk) if (frame_done) begin
    fd_count++;
    fd_qsize = cap.size();
  end

  function automatic logic [7:0] pad(input string s, input int i);
    pad = (i < s.len()) ? 8'(s[i]) : 8'h20;
  endfunction

  task automatic wait_cap(input int want, input int limit, input string tag);
    int n = 0;
    while (cap.size() < want && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (cap.size() < want) begin
      checks++; failures++;
      $display("FAIL %s_timeout: captured %0d bytes, required %0d", tag, cap.size(), want);
    end
  endtask

  task automatic check_powerup(input string tag);
    int n = 1;
    @(negedge clk);
    checks++;
    if (LCD_ON !== 1'b1) begin failures++; $display("FAIL %s_lcd_on: got %b required 1", tag, LCD_ON); end
    while (LCD_EN !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 22) begin failures++; $display("FAIL %s_first_strobe: at clock %0d required 22", tag, n); end
    checks++;
    if ({LCD_RS, LCD_DATA} !== 9'h038) begin
      failures++; $display("FAIL %s_first_byte: rs=%b data=%h required rs=0 data=38", tag, LCD_RS, LCD_DATA);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    state_code = 5'b00000;
    repeat (3) @(negedge clk);
    checks++;
    if (char_index !== 5'h00 || LCD_DATA !== 8'h00 || LCD_RS !== 1'b0 || LCD_RW !== 1'b0) begin
      failures++;
      $display("FAIL reset_bus: idx=%h data=%h rs=%b rw=%b required all 0", char_index, LCD_DATA, LCD_RS, LCD_RW);
    end
    checks++;
    if (LCD_EN !== 1'b0 || LCD_ON !== 1'b0 || init_done !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: en=%b on=%b init=%b frame=%b required all 0", LCD_EN, LCD_ON, init_done, frame_done);
    end
    cap.delete();
    reset_n = 1'b1;
    check_powerup("reset");
  endtask

  task automatic test_init_order();
    logic [7:0] exp_init[5] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    int n = 0;
    logic prev_init = 1'b0;
    wait_cap(5, 300, "init");
    if (cap.size() < 5) return;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[i] !== {1'b0, exp_init[i]}) begin
        failures++; $display("FAIL init_byte%0d: got %h required %h", i, cap[i], {1'b0, exp_init[i]});
      end
    end
    checks++;
    if (init_done !== 1'b0) begin failures++; $display("FAIL init_done_early: got %b required 0", init_done); end
    while (LCD_DATA !== 8'h80 && n < 50) begin
      prev_init = init_done;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 15) begin failures++; $display("FAIL clear_gap: got %0d clocks required 15", n); end
    checks++;
    if (prev_init !== 1'b0 || init_done !== 1'b1) begin
      failures++; $display("FAIL init_done_rise: before=%b after=%b required 0 then 1", prev_init, init_done);
    end
  endtask

  task automatic test_frame();
    wait_cap(40, 800, "frame");
    if (cap.size() < 40) return;
    checks++;
    if (cap[5] !== 9'h080) begin failures++; $display("FAIL frame_l1_addr: got %h required 080", cap[5]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[6+i] !== {1'b1, pad("Start", i)}) begin
        failures++; $display("FAIL frame_l1_char%0d: got %h required %h", i, cap[6+i], {1'b1, pad("Start", i)});
      end
    end
    checks++;
    if (cap[22] !== 9'h0C0) begin failures++; $display("FAIL frame_l2_addr: got %h required 0c0", cap[22]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[23+i] !== {1'b1, pad("Press Ok", i)}) begin
        failures++; $display("FAIL frame_l2_char%0d: got %h required %h", i, cap[23+i], {1'b1, pad("Press Ok", i)});
      end
    end
    checks++;
    if (cap[39] !== 9'h080) begin failures++; $display("FAIL frame_repeat: got %h required 080", cap[39]); end
    checks++;
    if (fd_count !== 1 || fd_qsize !== 39) begin
      failures++; $display("FAIL frame_done: pulses=%0d at byte %0d required 1 at 39", fd_count, fd_qsize);
    end
  endtask

  task automatic test_strobe_timing();
    int n = 0, lo = 0, hi = 0, unstable = 0;
    logic [8:0] held;
    while ({LCD_RS, LCD_DATA} === 9'h080 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 5) begin failures++; $display("FAIL fall_to_load: got %0d clocks required 5", n); end
    checks++;
    if ({LCD_RS, LCD_DATA} !== {1'b1, 8'h53}) begin
      failures++; $display("FAIL timing_byte: got %h required 153", {LCD_RS, LCD_DATA});
    end
    held = {LCD_RS, LCD_DATA};
    while (LCD_EN !== 1'b1 && lo < 20) begin
      if ({LCD_RS, LCD_DATA} !== held) unstable++;
      @(negedge clk);
      lo++;
    end
    checks++;
    if (lo !== 2) begin failures++; $display("FAIL setup_time: got %0d clocks required 2", lo); end
    while (LCD_EN === 1'b1 && hi < 20) begin
      if ({LCD_RS, LCD_DATA} !== held) unstable++;
      @(negedge clk);
      hi++;
    end
    checks++;
    if (hi !== 3) begin failures++; $display("FAIL en_width: got %0d clocks required 3", hi); end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL bus_stable: %0d changes required 0", unstable); end
  endtask

  task automatic test_message_switch();
    int fd_before = fd_count;
    wait_cap(61, 500, "switch_pre");
    repeat (7) @(negedge clk);
    checks++;
    if (LCD_EN !== 1'b1) begin failures++; $display("FAIL switch_in_strobe: en=%b required 1", LCD_EN); end
    state_code = 5'b10000;
    wait_cap(79, 500, "switch");
    if (cap.size() < 79) return;
    checks++;
    if (cap[61] !== {1'b1, 8'h73}) begin failures++; $display("FAIL switch_completes: got %h required 173", cap[61]); end
    checks++;
    if (cap[62] !== 9'h080) begin failures++; $display("FAIL switch_restart: got %h required 080", cap[62]); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[63+i] !== {1'b1, pad("Done", i)}) begin
        failures++; $display("FAIL switch_l1_char%0d: got %h required %h", i, cap[63+i], {1'b1, pad("Done", i)});
      end
    end
    checks++;
    if (fd_count !== fd_before) begin
      failures++; $display("FAIL switch_no_frame_done: pulses=%0d required %0d", fd_count, fd_before);
    end
  endtask

  task automatic test_mid_write_reset();
    int n = 0;
    while (LCD_EN !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (LCD_EN !== 1'b1) begin failures++; $display("FAIL midreset_find_en: en=%b required 1", LCD_EN); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (LCD_EN !== 1'b0 || init_done !== 1'b0 || char_index !== 5'h00) begin
      failures++; $display("FAIL midreset_async: en=%b init=%b idx=%h required 0 0 00", LCD_EN, init_done, char_index);
    end
    repeat (2) @(negedge clk);
    cap.delete();
    reset_n = 1'b1;
    check_powerup("midreset");
    wait_cap(1, 40, "midreset");
    if (cap.size() < 1) return;
    checks++;
    if (cap[0] !== 9'h038) begin failures++; $display("FAIL midreset_byte0: got %h required 038", cap[0]); end
  endtask

  initial begin
    test_reset();
    test_init_order();
    test_frame();
    test_strobe_timing();
    test_message_switch();
    test_mid_write_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
